// File: rtl/loop_pkg.sv
// Shared encodings for the loop sequencer: loop modes, completion reasons, FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package loop_pkg;

    typedef enum logic [1:0] {
        MODE_REPEAT   = 2'd0,
        MODE_WHILE    = 2'd1,
        MODE_DO_WHILE = 2'd2,
        MODE_FOR      = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        REASON_NORMAL   = 2'd0,
        REASON_BREAK    = 2'd1,
        REASON_WATCHDOG = 2'd2
    } reason_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_BODY  = 3'd2,
        ST_STEP  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/loop_check.sv
// Evaluates whether the loop should run another body and whether the watchdog limit is hit.
// Latency: purely combinational.
// Backpressure: none; the caller decides priority (watchdog before go).
module loop_check
    import loop_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MAX_ITER = 1024
) (
    input  mode_e              mode,
    input  logic [WIDTH-1:0]   iter_num,
    input  logic [WIDTH-1:0]   init,
    input  logic [WIDTH-1:0]   loop_var,
    input  logic [WIDTH-1:0]   limit,
    input  logic               cond,
    output logic               go,
    output logic               watchdog
);

    assign watchdog = (iter_num == WIDTH'(MAX_ITER));

    // Mode-specific continue condition
    always_comb begin
        go = 1'b0;
        case (mode)
            MODE_REPEAT:   go = (iter_num < init);
            MODE_WHILE:    go = cond;
            MODE_DO_WHILE: go = cond;
            MODE_FOR:      go = (loop_var < limit);
            default:       go = 1'b0;
        endcase
    end

endmodule

// File: rtl/loop_sequencer.sv
// Hardware loop sequencer running REPEAT/WHILE/DO_WHILE/FOR with break, continue and a watchdog.
// Latency: start->first body 2 cycles (1 for DO_WHILE); body completion->next body 3 cycles.
// Backpressure: start_ready only in IDLE; body holds until iter_ready, cont or brk.
module loop_sequencer
    import loop_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MAX_ITER = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_valid,
    output logic               start_ready,
    input  mode_e              mode,
    input  logic [WIDTH-1:0]   init,
    input  logic [WIDTH-1:0]   limit,
    input  logic [WIDTH-1:0]   step,
    input  logic               cond,
    input  logic               brk,
    input  logic               cont,
    output logic               iter_valid,
    input  logic               iter_ready,
    output logic [WIDTH-1:0]   iter_idx,
    output logic [WIDTH-1:0]   iter_num,
    output logic               done,
    output logic [WIDTH-1:0]   done_count,
    output reason_e            done_reason
);

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [WIDTH-1:0]   init_q, init_d;
    logic [WIDTH-1:0]   limit_q, limit_d;
    logic [WIDTH-1:0]   step_q, step_d;
    logic [WIDTH-1:0]   var_q, var_d;
    logic [WIDTH-1:0]   iter_num_q, iter_num_d;
    logic [WIDTH-1:0]   done_count_q, done_count_d;
    reason_e            done_reason_q, done_reason_d;

    logic               go;
    logic               watchdog;

    loop_check #(
        .WIDTH    (WIDTH),
        .MAX_ITER (MAX_ITER)
    ) u_check (
        .mode     (mode_q),
        .iter_num (iter_num_q),
        .init     (init_q),
        .loop_var (var_q),
        .limit    (limit_q),
        .cond     (cond),
        .go       (go),
        .watchdog (watchdog)
    );

    // Next-state and datapath updates; every field holds unless its state touches it
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        init_d        = init_q;
        limit_d       = limit_q;
        step_d        = step_q;
        var_d         = var_q;
        iter_num_d    = iter_num_q;
        done_count_d  = done_count_q;
        done_reason_d = done_reason_q;
        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    mode_d     = mode;
                    init_d     = init;
                    limit_d    = limit;
                    step_d     = step;
                    var_d      = (mode == MODE_FOR) ? init : '0;
                    iter_num_d = '0;
                    state_d    = (mode == MODE_DO_WHILE) ? ST_BODY : ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (watchdog) begin
                    state_d       = ST_DONE;
                    done_count_d  = iter_num_q;
                    done_reason_d = REASON_WATCHDOG;
                end else if (go) begin
                    state_d = ST_BODY;
                end else begin
                    state_d       = ST_DONE;
                    done_count_d  = iter_num_q;
                    done_reason_d = REASON_NORMAL;
                end
            end
            ST_BODY: begin
                // Break wins over continue and the handshake; the iteration is not counted
                if (brk) begin
                    state_d       = ST_DONE;
                    done_count_d  = iter_num_q;
                    done_reason_d = REASON_BREAK;
                end else if (cont || iter_ready) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                iter_num_d = iter_num_q + WIDTH'(1);
                // FOR variable wraps silently; the watchdog bounds a wrapped loop
                if (mode_q == MODE_FOR) begin
                    var_d = var_q + step_q;
                end
                state_d = ST_CHECK;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and operand registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            mode_q        <= MODE_REPEAT;
            init_q        <= '0;
            limit_q       <= '0;
            step_q        <= '0;
            var_q         <= '0;
            iter_num_q    <= '0;
            done_count_q  <= '0;
            done_reason_q <= REASON_NORMAL;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            init_q        <= init_d;
            limit_q       <= limit_d;
            step_q        <= step_d;
            var_q         <= var_d;
            iter_num_q    <= iter_num_d;
            done_count_q  <= done_count_d;
            done_reason_q <= done_reason_d;
        end
    end

    assign start_ready = (state_q == ST_IDLE);
    assign iter_valid  = (state_q == ST_BODY);
    assign done        = (state_q == ST_DONE);
    assign iter_idx    = (mode_q == MODE_FOR) ? var_q : iter_num_q;
    assign iter_num    = iter_num_q;
    assign done_count  = done_count_q;
    assign done_reason = done_reason_q;

endmodule

// File: tb/tb_loop_sequencer.sv
// Self-checking bench for loop_sequencer: directed loops plus randomized loops against a model.
// Latency: expected event cycles derived from the documented timing.
// Backpressure: body handshake driven directly and randomly by the bench.
module tb_loop_sequencer;
    import loop_pkg::*;

    localparam int W    = 8;
    localparam int MAXI = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start_valid;
    logic           start_ready;
    mode_e          mode;
    logic [W-1:0]   init;
    logic [W-1:0]   limit;
    logic [W-1:0]   step;
    logic           cond;
    logic           brk;
    logic           cont;
    logic           iter_valid;
    logic           iter_ready;
    logic [W-1:0]   iter_idx;
    logic [W-1:0]   iter_num;
    logic           done;
    logic [W-1:0]   done_count;
    reason_e        done_reason;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    loop_sequencer #(.WIDTH(W), .MAX_ITER(MAXI)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .mode        (mode),
        .init        (init),
        .limit       (limit),
        .step        (step),
        .cond        (cond),
        .brk         (brk),
        .cont        (cont),
        .iter_valid  (iter_valid),
        .iter_ready  (iter_ready),
        .iter_idx    (iter_idx),
        .iter_num    (iter_num),
        .done        (done),
        .done_count  (done_count),
        .done_reason (done_reason)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        n++;
    endtask

    // Loop variable of iteration k in FOR mode: init + k*step modulo 2^W
    function automatic int mvar(input int ini, input int stp, input int k);
        return (ini + stp * k) % 256;
    endfunction

    // Whether iteration k (k iterations already completed) should run
    function automatic bit mgo(input int m, input int ini, input int lim, input int stp,
                               input bit c, input int k);
        case (m)
            0:       return k < ini;
            1, 2:    return c;
            default: return mvar(ini, stp, k) < lim;
        endcase
    endfunction

    function automatic int midx(input int m, input int ini, input int stp, input int k);
        return (m == 3) ? mvar(ini, stp, k) : k;
    endfunction

    // Runs one loop from the current negedge (DUT idle) to one cycle after done
    task automatic run_loop(input int m, input int ini, input int lim, input int stp,
                            input bit c, input int brk_at, input bit brk_cont,
                            input int cont_at, input bit rnd);
        int  k;
        int  exp_n;
        int  ev;
        int  hold;
        int  exp_reason;
        bit  body_next;
        bit  fin;
        bit  left;
        bit  b;
        bit  ct;
        bit  rd;
        chk("start_ready_idle", start_ready, 1);
        mode        = mode_e'(m[1:0]);
        init        = ini[7:0];
        limit       = lim[7:0];
        step        = stp[7:0];
        cond        = c;
        start_valid = 1'b1;
        n = 0;
        tick();
        start_valid = 1'b0;
        chk("start_ready_fall", start_ready, 0);
        k          = 0;
        fin        = 0;
        exp_reason = 0;
        ev         = 0;
        if (m == 2) begin
            body_next = 1; exp_n = 1;
        end else if (mgo(m, ini, lim, stp, c, 0)) begin
            body_next = 1; exp_n = 2;
        end else begin
            body_next = 0; exp_n = 2;
        end
        while (!fin) begin
            while (n < exp_n) begin
                chk("quiet_valid", iter_valid, 0);
                chk("quiet_done", done, 0);
                brk        = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                cont       = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                iter_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                tick();
            end
            if (body_next) begin
                chk("body_valid", iter_valid, 1);
                chk("body_idx", iter_idx, midx(m, ini, stp, k));
                chk("body_num", iter_num, k);
                chk("body_done", done, 0);
                chk("body_start_ready", start_ready, 0);
                hold = 0;
                left = 0;
                while (!left) begin
                    b = 0; ct = 0; rd = 1;
                    if (rnd) begin
                        b  = ($urandom_range(0, 15) == 0);
                        ct = ($urandom_range(0, 7) == 0);
                        rd = 1'($urandom_range(0, 1));
                    end
                    if (k == cont_at) begin
                        rd = 0; ct = (hold > 0);
                    end
                    if (k == brk_at) begin
                        b = 1; ct = brk_cont;
                    end
                    if (hold >= 6) rd = 1;
                    brk = b; cont = ct; iter_ready = rd;
                    tick();
                    if (b) begin
                        exp_n      = n;
                        body_next  = 0;
                        exp_reason = 1;
                        left       = 1;
                    end else if (ct || rd) begin
                        ev = n - 1;
                        k++;
                        exp_n = ev + 3;
                        if (k == MAXI) begin
                            body_next = 0; exp_reason = 2;
                        end else if (mgo(m, ini, lim, stp, c, k)) begin
                            body_next = 1;
                        end else begin
                            body_next = 0; exp_reason = 0;
                        end
                        left = 1;
                    end else begin
                        hold++;
                        chk("hold_valid", iter_valid, 1);
                        chk("hold_idx", iter_idx, midx(m, ini, stp, k));
                        chk("hold_num", iter_num, k);
                    end
                end
            end else begin
                chk("done_pulse", done, 1);
                chk("done_valid", iter_valid, 0);
                chk("done_count", done_count, k);
                chk("done_reason", done_reason, exp_reason);
                brk = 0; cont = 0; iter_ready = 0;
                tick();
                chk("done_single", done, 0);
                chk("ready_back", start_ready, 1);
                chk("count_held", done_count, k);
                chk("reason_held", done_reason, exp_reason);
                fin = 1;
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        start_valid = 1'b0;
        mode        = MODE_REPEAT;
        init        = '0;
        limit       = '0;
        step        = '0;
        cond        = 1'b0;
        brk         = 1'b0;
        cont        = 1'b0;
        iter_ready  = 1'b0;
        tick();
        tick();
        chk("rst_start_ready", start_ready, 1);
        chk("rst_iter_valid", iter_valid, 0);
        chk("rst_iter_idx", iter_idx, 0);
        chk("rst_iter_num", iter_num, 0);
        chk("rst_done", done, 0);
        chk("rst_done_count", done_count, 0);
        chk("rst_done_reason", done_reason, 0);
        rst = 1'b0;
        tick();

        // mode, init, limit, step, cond, brk_at, brk_cont, cont_at, rnd
        run_loop(0, 3, 0, 0, 0, -1, 0, -1, 0);     // REPEAT 3
        run_loop(0, 0, 0, 0, 0, -1, 0, -1, 0);     // REPEAT 0
        run_loop(3, 2, 10, 3, 0, -1, 0, -1, 0);    // FOR 2,5,8
        run_loop(3, 5, 5, 1, 0, -1, 0, -1, 0);     // FOR empty
        run_loop(1, 0, 0, 0, 0, -1, 0, -1, 0);     // WHILE cond=0
        run_loop(2, 0, 0, 0, 0, -1, 0, -1, 0);     // DO_WHILE cond=0
        run_loop(3, 0, 10, 1, 0, 4, 0, 2, 0);      // cont at 2, brk at 4
        run_loop(3, 0, 10, 1, 0, 1, 1, -1, 0);     // brk with cont
        run_loop(1, 0, 0, 0, 1, -1, 0, -1, 0);     // WHILE watchdog
        run_loop(3, 250, 255, 4, 0, -1, 0, -1, 0); // FOR wrap to watchdog

        // Reset in the middle of a body
        mode = MODE_FOR; init = 8'd0; limit = 8'd10; step = 8'd1;
        start_valid = 1'b1;
        n = 0;
        tick();
        start_valid = 1'b0;
        iter_ready  = 1'b1;
        tick();
        chk("rr_body0_idx", iter_idx, 0);
        tick();
        iter_ready = 1'b0;
        tick();
        tick();
        chk("rr_body1_valid", iter_valid, 1);
        chk("rr_body1_idx", iter_idx, 1);
        rst = 1'b1;
        tick();
        chk("rr_start_ready", start_ready, 1);
        chk("rr_iter_valid", iter_valid, 0);
        chk("rr_done", done, 0);
        chk("rr_iter_num", iter_num, 0);
        rst = 1'b0;
        tick();
        chk("rr_no_done", done, 0);
        chk("rr_idle", start_ready, 1);
        run_loop(0, 2, 0, 0, 0, -1, 0, -1, 0);

        // Randomized loops
        for (int i = 0; i < 40; i++) begin
            int m;
            int ini;
            m   = int'($urandom_range(0, 3));
            ini = (m == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 255));
            run_loop(m, ini, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)), -1, 0, -1, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/loop_sequencer.md
# loop_sequencer

Parametrised hardware loop sequencer that executes REPEAT, WHILE, DO_WHILE and FOR loop semantics as a cycle-level state machine. Each loop body is issued through a valid/ready handshake, and the body can be ended early with break or continue. An iteration watchdog bounds non-terminating loops. The block is the sequential counterpart of the statement-level test designs and serves as a simulator regression design for loop control flow, handshakes and counter wrap.

## Interface
- WIDTH, 32, width of loop variable, bounds, step and counters
- MAX_ITER, 1024, watchdog limit on completed iterations (≥1, < 2^WIDTH)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start_valid  in  1  loop request
- start_ready  out  1  high only in IDLE
- mode  in  2  loop_pkg::mode_e: REPEAT=0, WHILE=1, DO_WHILE=2, FOR=3
- init  in  WIDTH  REPEAT: iteration count; FOR: initial loop variable
- limit  in  WIDTH  FOR: exclusive unsigned upper bound
- step  in  WIDTH  FOR: increment
- cond  in  1  WHILE/DO_WHILE condition, sampled in CHECK
- brk  in  1  break, sampled in BODY
- cont  in  1  continue, sampled in BODY
- iter_valid  out  1  body active
- iter_ready  in  1  body complete
- iter_idx  out  WIDTH  current loop variable (FOR) or iteration number (others)
- iter_num  out  WIDTH  completed-iteration count
- done  out  1  one-cycle completion pulse
- done_count  out  WIDTH  completed iterations, valid with done
- done_reason  out  2  loop_pkg::reason_e: NORMAL=0, BREAK=1, WATCHDOG=2

## Operation
- States: IDLE, CHECK, BODY, STEP, DONE.
- IDLE: start_valid and start_ready together latch mode, init, limit and step. The loop variable loads init in FOR mode and 0 otherwise. iter_num clears. Next state is BODY for DO_WHILE and CHECK for all other modes.
- CHECK: the first true rule in this priority order applies:
  - iter_num == MAX_ITER → DONE, reason WATCHDOG.
  - Mode-specific continue condition true → BODY:
    - REPEAT: iter_num < init.
    - WHILE and DO_WHILE: cond.
    - FOR: var < limit (unsigned).
  - Otherwise → DONE, reason NORMAL.
- BODY: iter_valid=1. The first matching rule applies:
  - brk → DONE, reason BREAK. No STEP, so iter_num is unchanged.
  - cont, or iter_valid && iter_ready → STEP.
  - Otherwise hold in BODY.
- brk has priority over cont and over the handshake.
- STEP: iter_num += 1. In FOR mode, var += step, wrapping modulo 2^WIDTH with no wrap detection; the watchdog bounds a wrapped loop. Next state is CHECK.
- DONE: done=1 for one cycle, done_count=iter_num, then IDLE.
- done_count and done_reason are held until the next done.
- rst in any state forces IDLE with no done pulse. An in-flight loop is discarded.
- Reset values: start_ready=1, all other outputs 0.

## Timing
- start accepted at cycle t:
  - CHECK at t+1.
  - First BODY (iter_valid) at t+2, or at t+1 for DO_WHILE.
- Handshake or cont at cycle b:
  - STEP at b+1, CHECK at b+2, next BODY at b+3.
- A loop with zero iterations gives done at t+2.
- Break at cycle b gives done at b+1.
- iter_valid, iter_idx and iter_num are registered and stable throughout BODY.
- start_ready falls the cycle after acceptance. It returns high the cycle after done.
- cond is sampled only in CHECK. brk and cont are sampled only in BODY, and are ignored in every other state.

## Structure
- loop_pkg holds mode_e, reason_e, state_e, and the MODE_* and REASON_* encodings.
- One sub-module, loop_check: a combinational evaluator. Inputs: mode, iter_num, init, var, limit, cond. Outputs: go, watchdog.
- loop_sequencer contains the FSM, the latched operand registers and the counters.

## Test plan
- REPEAT, init=3, iter_ready=1 → three BODY cycles with iter_idx 0, 1, 2 → done, done_count=3, reason NORMAL. REPEAT with init=0 → no iter_valid, done at t+2, done_count=0.
- FOR, init=2, limit=10, step=3 → iter_idx 2, 5, 8 → done_count=3, NORMAL. FOR, init=limit=5 → zero iterations.
- cond=0 held: WHILE → 0 iterations; DO_WHILE → exactly 1 iteration, done_count=1.
- FOR 0..10, step 1, iter_ready=0 with cont at iter_idx 2 → iteration advances without a handshake. brk at iter_idx 4 → done one cycle later, done_count=4, reason BREAK. brk and cont asserted together → BREAK.
- WHILE with cond=1 held and MAX_ITER=8 → 8 iterations, then done_count=8, reason WATCHDOG. FOR with WIDTH=8, init=250, limit=255, step=4 → var wraps to 2, loop continues until the watchdog fires.
- rst asserted in BODY at iter_idx 1 → next cycle IDLE, start_ready=1, iter_valid=0, no done pulse. A new start then runs normally.
